// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared state encoding and default geometry for the block copier
package ram_copy_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/ram_block_copier_if.sv
// ram_block_copier_if: copy request/status handshake plus the single-port RAM bus
interface ram_block_copier_if import ram_copy_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;
    modport master (
        input  start, src, dst, len, ram_out,
        output busy, done, ram_addr, ram_in, ram_load
    );
    modport slave (
        output start, src, dst, len, ram_out,
        input  busy, done, ram_addr, ram_in, ram_load
    );
endinterface

// File: rtl/ram_4k.sv
// ram_4k: single-port RAM, synchronous write, combinational read
module ram_4k import ram_copy_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (load_i) mem_q[addr_i] <= data_i;
    end
    assign data_o = mem_q[addr_i];
endmodule

// File: rtl/ram_block_copier.sv
// ram_block_copier: copies len words from src to dst, one READ/WRITE pair per word, ascending
module ram_block_copier import ram_copy_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic                clock,
    input logic                reset,
    ram_block_copier_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d, i_q, i_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d   = bus.src;
                dst_d   = bus.dst;
                len_d   = bus.len;
                i_d     = '0;
                state_d = (bus.len == '0) ? DONE : READ;
            end
            READ: begin
                data_d  = bus.ram_out;
                state_d = WRITE;
            end
            WRITE: begin
                i_d     = i_q + 1'b1;
                state_d = (i_q + 1'b1 == len_q) ? DONE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // index is one bit wider than the address so len=4096 terminates; addresses wrap naturally
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
    assign bus.ram_load = state_q == WRITE;
    assign bus.ram_addr = (state_q == READ)  ? src_q + i_q[ADDR_W-1:0] :
                          (state_q == WRITE) ? dst_q + i_q[ADDR_W-1:0] : '0;
    assign bus.ram_in   = (state_q == WRITE) ? data_q : '0;
endmodule
